// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues a mult/div from DX to the iterative multdiv unit,
// stalls the front of the pipeline while it runs (bounded by a watchdog), and
// injects one writeback record into XM when it completes.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   mult_req, div_req     - DX holds a mult / div instruction
//   flush                 - DX is being squashed; blocks acceptance
//   opA_in, opB_in, rd_in - DX operands and destination register
//   md_ready, md_exception, md_result - multdiv unit completion interface
//   md_ctrl_mult/div      - one-cycle start pulse to the unit
//   md_opA, md_opB        - latched operands held for the unit
//   stall, busy           - pipeline freeze / operation outstanding
//   wb_valid, wb_reg, wb_data - writeback record for the XM latch
module multdiv_sequencer #(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mult_req,
    input  logic        div_req,
    input  logic        flush,
    input  logic [31:0] opA_in,
    input  logic [31:0] opB_in,
    input  logic [4:0]  rd_in,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 6;

    localparam logic [REG_W-1:0]  RSTATUS_REG = REG_W'(30);
    localparam logic [DATA_W-1:0] EXC_MULT    = DATA_W'(4);
    localparam logic [DATA_W-1:0] EXC_DIV     = DATA_W'(5);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                start_mult_q, start_mult_d;
    logic                start_div_q, start_div_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]    wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic                accept_c;
    logic                first_busy_c;
    logic [DATA_W-1:0]   exc_code_c;

    // A new op may enter whenever nothing is in flight; reset also blocks it
    assign accept_c     = !reset && (state_q != S_BUSY) && (mult_req || div_req) && !flush;
    // The start-pulse cycle is the first BUSY cycle; md_ready is not trusted there
    assign first_busy_c = start_mult_q || start_div_q;
    assign exc_code_c   = is_div_q ? EXC_DIV : EXC_MULT;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_div_q     <= 1'b0;
            rd_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_reg_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_div_q     <= is_div_d;
            rd_q         <= rd_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            start_mult_q <= start_mult_d;
            start_div_q  <= start_div_d;
            wb_valid_q   <= wb_valid_d;
            wb_reg_q     <= wb_reg_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_div_d     = is_div_q;
        rd_d         = rd_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        start_mult_d = 1'b0;
        start_div_d  = 1'b0;
        wb_valid_d   = 1'b0;
        wb_reg_d     = '0;
        wb_data_d    = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_c) begin
                    state_d      = S_BUSY;
                    cnt_d        = '0;
                    is_div_d     = !mult_req;
                    rd_d         = rd_in;
                    op_a_d       = opA_in;
                    op_b_d       = opB_in;
                    start_mult_d = mult_req;
                    start_div_d  = !mult_req;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real result beats the watchdog when both land together
                if (md_ready && !first_busy_c) begin
                    state_d    = S_DONE;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = md_exception ? RSTATUS_REG : rd_q;
                    wb_data_d  = md_exception ? exc_code_c : md_result;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_DONE;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = RSTATUS_REG;
                    wb_data_d  = exc_code_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        stall        = accept_c || (state_q == S_BUSY);
        busy         = (state_q == S_BUSY);
        md_ctrl_mult = start_mult_q;
        md_ctrl_div  = start_div_q;
        md_opA       = op_a_q;
        md_opB       = op_b_q;
        wb_valid     = wb_valid_q;
        wb_reg       = wb_reg_q;
        wb_data      = wb_data_q;
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: stimulus pushes the expected
// writeback record; a negedge monitor pops and compares each wb_valid.
module tb_multdiv_sequencer;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        mult_req, div_req, flush;
    logic [31:0] opA_in, opB_in;
    logic [4:0]  rd_in;
    logic        md_ready, md_exception;
    logic [31:0] md_result;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_opA, md_opB;
    logic        stall, busy, wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;
    wb_t exp_q[$];

    multdiv_sequencer #(.MAX_CYCLES(40)) dut (
        .clock(clock), .reset(reset),
        .mult_req(mult_req), .div_req(div_req), .flush(flush),
        .opA_in(opA_in), .opB_in(opB_in), .rd_in(rd_in),
        .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_opA(md_opA), .md_opB(md_opB),
        .stall(stall), .busy(busy),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        mult_req = 0; div_req = 0; flush = 0;
        md_ready = 0; md_exception = 0; md_result = '0;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        mult_req = m; div_req = d; opA_in = a; opB_in = b; rd_in = rd;
    endtask

    // Monitor: every writeback must match the oldest expected record
    always @(negedge clock) begin
        if (wb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: reg %0d data 0x%0h at %0t", wb_reg, wb_data, $time);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (wb_reg !== e.r || wb_data !== e.d) begin
                    errors++;
                    $display("FAIL wb_record: got reg %0d data 0x%0h expected reg %0d data 0x%0h at %0t",
                             wb_reg, wb_data, e.r, e.d, $time);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        opA_in = '0; opB_in = '0; rd_in = '0;

        // Reset held with a pending mult request
        reset = 1;
        issue(1, 0, 32'd1, 32'd2, 5'd4);
        step();
        step();
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulse", 32'({md_ctrl_mult, md_ctrl_div}), 0);
        chk("rst_opA", md_opA, 0);
        chk("rst_wb", 32'({wb_valid, wb_reg}), 0);
        chk("rst_wbdata", wb_data, 0);
        reset = 0;
        exp_q.push_back('{r: 5'd4, d: 32'd2});
        #1 chk("rel_stall", 32'(stall), 1);
        step();                                 // cycle 1
        clear_inputs();
        chk("rel_pulse", 32'(md_ctrl_mult), 1);
        chk("rel_busy", 32'(busy), 1);
        step();                                 // cycle 2
        md_ready = 1; md_result = 32'd2;
        step();                                 // cycle 3
        clear_inputs();
        chk("rel_wbv", 32'(wb_valid), 1);
        step();

        // Mult 7*6 -> r3, ready at cycle 5
        issue(1, 0, 32'd7, 32'd6, 5'd3);
        exp_q.push_back('{r: 5'd3, d: 32'd42});
        #1 chk("mul_c0_stall", 32'(stall), 1);
        chk("mul_c0_pulse", 32'(md_ctrl_mult), 0);
        step();                                 // cycle 1
        clear_inputs();
        chk("mul_c1_pulse", 32'({md_ctrl_mult, md_ctrl_div}), 32'b10);
        chk("mul_c1_opA", md_opA, 7);
        chk("mul_c1_opB", md_opB, 6);
        step();                                 // cycle 2
        chk("mul_c2_pulse", 32'(md_ctrl_mult), 0);
        chk("mul_c2_stall", 32'(stall), 1);
        step(); step(); step();                 // cycle 5
        md_ready = 1; md_result = 32'd42;
        #1 chk("mul_c5_stall", 32'(stall), 1);
        chk("mul_c5_wbv", 32'(wb_valid), 0);
        step();                                 // cycle 6
        clear_inputs();
        chk("mul_c6_stall", 32'(stall), 0);
        chk("mul_c6_busy", 32'(busy), 0);
        chk("mul_c6_wbv", 32'(wb_valid), 1);
        chk("mul_c6_opA", md_opA, 7);
        step();                                 // cycle 7
        chk("mul_c7_wbv", 32'(wb_valid), 0);
        chk("mul_c7_wbdata", wb_data, 0);

        // Div by zero -> rstatus 5; ready during the pulse cycle is ignored
        issue(0, 1, 32'd50, 32'd0, 5'd9);
        exp_q.push_back('{r: 5'd30, d: 32'd5});
        step();                                 // cycle 1
        clear_inputs();
        chk("div_pulse", 32'({md_ctrl_mult, md_ctrl_div}), 32'b01);
        md_ready = 1; md_result = 32'd123;
        step();                                 // cycle 2
        chk("div_first_ignored", 32'(busy), 1);
        clear_inputs();
        step();                                 // cycle 3
        md_ready = 1; md_exception = 1;
        step();                                 // cycle 4
        clear_inputs();
        chk("div_wbv", 32'(wb_valid), 1);
        step();
        chk("div_single_wb", 32'(wb_valid), 0);

        // Watchdog timeout on a mult -> rstatus 4 at cycle 41
        issue(1, 0, 32'd3, 32'd3, 5'd11);
        exp_q.push_back('{r: 5'd30, d: 32'd4});
        step();                                 // cycle 1
        clear_inputs();
        for (int c = 2; c <= 40; c++) step();   // cycle 40
        chk("to_c40_stall", 32'(stall), 1);
        chk("to_c40_wbv", 32'(wb_valid), 0);
        step();                                 // cycle 41
        chk("to_c41_wbv", 32'(wb_valid), 1);
        chk("to_c41_stall", 32'(stall), 0);
        step();

        // Ready on the terminal-count cycle: result wins
        issue(1, 0, 32'd11, 32'd7, 5'd12);
        exp_q.push_back('{r: 5'd12, d: 32'd77});
        step();
        clear_inputs();
        for (int c = 2; c <= 40; c++) step();   // cycle 40
        md_ready = 1; md_result = 32'd77;
        step();                                 // cycle 41
        clear_inputs();
        chk("tc_wbv", 32'(wb_valid), 1);
        step();

        // Back-to-back: new div accepted in the DONE cycle
        issue(0, 1, 32'd100, 32'd7, 5'd5);
        exp_q.push_back('{r: 5'd5, d: 32'd14});
        step();                                 // cycle 1
        clear_inputs();
        step(); step();                         // cycle 3
        md_ready = 1; md_result = 32'd14;
        step();                                 // cycle 4 (DONE)
        clear_inputs();
        issue(0, 1, 32'd9, 32'd3, 5'd6);
        exp_q.push_back('{r: 5'd6, d: 32'd3});
        #1 chk("b2b_done_stall", 32'(stall), 1);
        chk("b2b_done_wbv", 32'(wb_valid), 1);
        step();                                 // cycle 5
        clear_inputs();
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_pulse", 32'(md_ctrl_div), 1);
        chk("b2b_opA", md_opA, 9);
        step();
        md_ready = 1; md_result = 32'd3;
        step();
        clear_inputs();
        chk("b2b_wbv2", 32'(wb_valid), 1);
        step();

        // Flush blocks acceptance
        issue(1, 0, 32'd2, 32'd2, 5'd8);
        flush = 1;
        #1 chk("flush_stall", 32'(stall), 0);
        step();
        clear_inputs();
        chk("flush_busy", 32'(busy), 0);
        chk("flush_pulse", 32'(md_ctrl_mult), 0);
        step();

        // Reset at cycle 3 of BUSY: no writeback, later ready ignored
        issue(1, 0, 32'd5, 32'd5, 5'd7);
        step();                                 // cycle 1
        clear_inputs();
        step(); step();                         // cycle 3
        reset = 1;
        step();                                 // cycle 4
        reset = 0;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_stall", 32'(stall), 0);
        chk("mrst_pulse", 32'({md_ctrl_mult, md_ctrl_div}), 0);
        md_ready = 1; md_result = 32'd25;
        step();
        clear_inputs();
        chk("mrst_wbv", 32'(wb_valid), 0);
        chk("mrst_busy2", 32'(busy), 0);
        step(); step();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
